imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1001, giving the number of instruction-memory words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, giving the first word address written.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a load session.
REQ-006 The block SHALL have port in_valid, input, 1 bit: byte-stream source has a byte.
REQ-007 The block SHALL have port in_data, input, 8 bits: byte-stream data.
REQ-008 The block SHALL have port in_ready, output, 1 bit: loader can accept a byte.
REQ-009 The block SHALL have port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, 32 bits: word address, one word per address.
REQ-011 The block SHALL have port mem_wdata, output, 32 bits: instruction word to write.
REQ-012 The block SHALL have port busy, output, 1 bit: load in progress; holds the program counter in reset.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 The block SHALL have port err, output, 1 bit: sticky length-error flag.

Function
REQ-015 A byte SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; in_data is otherwise ignored.
REQ-016 States SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
REQ-017 IDLE SHALL drive in_ready=0 and busy=0, and SHALL go to LEN_HI on start=1.
REQ-018 LEN_HI then LEN_LO SHALL each accept one byte, forming 16-bit word count N, MSB first, with in_ready=1.
REQ-019 After LEN_LO, N=0 SHALL go to DONE, N>DEPTH SHALL go to ERR, and any other N SHALL go to DATA with word index 0.
REQ-020 DATA SHALL accept 4 bytes, MSB first, into a 32-bit shift register and go to WRITE after the 4th accepted byte.
REQ-021 WRITE SHALL last exactly one cycle with mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=assembled word, and in_ready=0.
REQ-022 From WRITE, the FSM SHALL go to DONE when index=N-1; otherwise it SHALL increment index and go to DATA.
REQ-023 Write latency SHALL be 1 cycle after the 4th byte is accepted; peak throughput SHALL be 1 word per 5 cycles.
REQ-024 mem_we SHALL be 0 in every state other than WRITE; mem_addr and mem_wdata SHALL hold their last values outside WRITE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, keep busy=1, then return to IDLE.
REQ-026 ERR SHALL assert err=1 with busy=0 and in_ready=0; start=1 SHALL clear err and go to LEN_HI.
REQ-027 start SHALL be ignored in LEN_HI, LEN_LO, DATA, WRITE and DONE.
REQ-028 busy SHALL be 1 in LEN_HI, LEN_LO, DATA, WRITE and DONE.
REQ-029 Stalls (in_valid=0) in any receiving state SHALL hold state, byte count and partial word unchanged.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE and set in_ready, mem_we, busy, done, err, mem_addr, mem_wdata, index, N and the shift register to 0.
REQ-031 Reset mid-load SHALL discard the partial word with no write; words already written SHALL NOT be rewritten.
REQ-032 After reset deassertion, the block SHALL stay in IDLE until start=1.

Structure
REQ-033 Package imem_pkg SHALL hold the state enumeration, the DEPTH default, and the 16-bit length width constant, shared with the fetch stage.
REQ-034 Byte-to-word assembly (shift register plus 2-bit byte counter, word_ready flag) SHALL be a sub-module named word_assembler.

Verification
REQ-035 Bytes 00 02 | 12 34 56 78 | 9A BC DE F0 after start -> writes 0x12345678 @0 then 0x9ABCDEF0 @1; done pulses 1 cycle after the last write.
REQ-036 Bytes 00 00 -> no mem_we; done=1 for exactly one cycle; busy returns to 0.
REQ-037 Length 0x03EA (1002) with DEPTH=1001 -> err=1, busy=0, no writes; next start clears err.
REQ-038 in_valid toggled every other cycle during the DATA bytes of REQ-035 -> identical writes, each write 1 cycle after its 4th accepted byte.
REQ-039 rst driven low after 2 of 4 bytes of word 1 -> all outputs 0 asynchronously; no write of word 1; a fresh load then works from index 0.
REQ-040 start pulsed during DATA -> ignored; the load completes unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch stage:
// loader state encoding, default memory depth and length-field width.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH_DEF = 1001;
    localparam int unsigned LEN_W          = 16;

    // Loader state encoding (kept as plain constants for legacy users)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_LEN_LO = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    // True when a requested word count does not fit in the memory
    function automatic logic len_too_long(input logic [LEN_W-1:0] len,
                                          input logic [31:0]      depth);
        return ({{(32-LEN_W){1'b0}}, len} > depth);
    endfunction

    // Word address of the given load index
    function automatic logic [31:0] word_addr(input logic [31:0]      base,
                                              input logic [LEN_W-1:0] idx);
        return base + {{(32-LEN_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-to-word assembly: collects four bytes MSB first. The word output
// already includes the byte being accepted, so the caller can register the
// complete word on the same edge that accepts the fourth byte.
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [31:0] shift_r;
    logic [1:0]  cnt_r;

    // Assembled word and completion flag for the byte currently offered
    always_comb begin
        word       = {shift_r[23:0], byte_in};
        word_ready = byte_en && (cnt_r == 2'd3);
    end

    // Shift register and byte counter; stalls leave both untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= 32'd0;
            cnt_r   <= 2'd0;
        end else if (clr) begin
            shift_r <= 32'd0;
            cnt_r   <= 2'd0;
        end else if (byte_en) begin
            shift_r <= {shift_r[23:0], byte_in};
            cnt_r   <= cnt_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit word count followed by
// 32-bit words as a byte stream and writes them to consecutive addresses
// starting at BASE_ADDR. busy holds the core's program counter in reset
// while a load is in progress. All outputs are registered.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = IMEM_DEPTH_DEF,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_nx_s;
    logic [LEN_W-1:0] idx_r;
    logic [LEN_W-1:0] idx_nx_s;

    logic             accept_s;
    logic             asm_en_s;
    logic             asm_clr_s;
    logic             asm_ready_s;
    logic [31:0]      asm_word_s;

    logic             in_ready_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic             in_ready_nx_s;
    logic             busy_nx_s;
    logic             done_nx_s;
    logic             err_nx_s;
    logic             mem_we_nx_s;

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

    // Byte handshake and assembler control
    always_comb begin
        accept_s  = in_valid && in_ready_r;
        asm_en_s  = accept_s && (state_r == ST_DATA);
        asm_clr_s = accept_s && (state_r == ST_LEN_LO);
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst),
        .clr        (asm_clr_s),
        .byte_en    (asm_en_s),
        .byte_in    (in_data),
        .word       (asm_word_s),
        .word_ready (asm_ready_s)
    );

    // Next-state, length and word-index logic
    always_comb begin
        state_nx_s = state_r;
        len_nx_s   = len_r;
        idx_nx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_LEN_HI;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_nx_s   = {in_data, len_r[7:0]};
                    state_nx_s = ST_LEN_LO;
                end else begin
                    state_nx_s = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_nx_s = {len_r[LEN_W-1:8], in_data};
                    idx_nx_s = {LEN_W{1'b0}};
                    if (len_nx_s == {LEN_W{1'b0}}) begin
                        state_nx_s = ST_DONE;
                    end else if (len_too_long(len_nx_s, DEPTH_W)) begin
                        state_nx_s = ST_ERR;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (asm_ready_s) begin
                    state_nx_s = ST_WRITE;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (idx_r == (len_r - 16'd1)) begin
                    state_nx_s = ST_DONE;
                end else begin
                    idx_nx_s   = idx_r + 16'd1;
                    state_nx_s = ST_DATA;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            ST_ERR: begin
                if (start) begin
                    state_nx_s = ST_LEN_HI;
                end else begin
                    state_nx_s = ST_ERR;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop
    always_comb begin
        in_ready_nx_s = 1'b0;
        busy_nx_s     = 1'b0;
        done_nx_s     = 1'b0;
        err_nx_s      = 1'b0;
        mem_we_nx_s   = 1'b0;
        case (state_nx_s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
                in_ready_nx_s = 1'b1;
                busy_nx_s     = 1'b1;
            end
            ST_WRITE: begin
                busy_nx_s   = 1'b1;
                mem_we_nx_s = 1'b1;
            end
            ST_DONE: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b1;
            end
            ST_ERR: begin
                err_nx_s = 1'b1;
            end
            default: begin
                in_ready_nx_s = 1'b0;
            end
        endcase
    end

    // FSM state, length and index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            len_r   <= {LEN_W{1'b0}};
            idx_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            len_r   <= len_nx_s;
            idx_r   <= idx_nx_s;
        end
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            mem_we_r   <= 1'b0;
        end else begin
            in_ready_r <= in_ready_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            err_r      <= err_nx_s;
            mem_we_r   <= mem_we_nx_s;
        end
    end

    // Memory address/data: loaded on entry to WRITE, held at all other times
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else if (mem_we_nx_s) begin
            mem_addr_r  <= word_addr(BASE_ADDR, idx_r);
            mem_wdata_r <= asm_word_s;
        end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: the driver pushes the
// expected memory image (address, word, cycle) and done pulses as it feeds
// bytes; a monitor pops and compares whenever the loader writes or pulses done.
module tb_imem_loader;

    localparam int          TB_DEPTH = 1001;
    localparam logic [31:0] TB_BASE  = 32'h0000_0040;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         wq[$];
    int          dq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_lo = 0;
    int          stall_hi = 0;
    logic [31:0] hold_addr = 32'd0;
    logic [31:0] hold_data = 32'd0;

    imem_loader #(.DEPTH(TB_DEPTH), .BASE_ADDR(TB_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare writes and done pulses against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            hold_addr = 32'd0;
            hold_data = 32'd0;
        end else begin
            checks++;
            if (mem_we) begin
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write got addr=%h data=%h cyc=%0d want none",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                                 mem_addr, mem_wdata, cyc, e.addr, e.data, e.cyc);
                    end
                    hold_addr = e.addr;
                    hold_data = e.data;
                end
            end else if (mem_addr !== hold_addr || mem_wdata !== hold_data) begin
                errors++;
                $display("FAIL hold got addr=%h data=%h want addr=%h data=%h",
                         mem_addr, mem_wdata, hold_addr, hold_data);
            end
            if (done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got done=1 cyc=%0d want 0", cyc);
                end else begin
                    int ec;
                    ec = dq.pop_front();
                    if (cyc != ec || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL done got cyc=%0d busy=%b want cyc=%0d busy=1",
                                 cyc, busy, ec);
                    end
                end
            end
        end
    end

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Offer one byte, with optional random stalls and random start pulses
    task automatic send_byte(input logic [7:0] b, input bit allow_start, output int acc);
        int  budget;
        bit  rdy;
        repeat ($urandom_range(stall_hi, stall_lo)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        acc      = -1;
        budget   = 0;
        while (acc < 0 && budget < 40) begin
            start = allow_start && ($urandom_range(0, 3) == 0);
            rdy   = in_ready;
            @(posedge clk); #1;
            if (rdy) acc = cyc;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout got in_ready=0 want 1");
        end
    endtask

    task automatic start_sess();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check1("session_open", {29'd0, busy, err, in_ready}, 32'd5);
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((wq.size() != 0 || dq.size() != 0) && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
        if (b >= 50) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending=%0d want 0", wq.size() + dq.size());
        end
        repeat (2) @(posedge clk);
        #1;
        check1("idle_after", {29'd0, busy, err, in_ready}, 32'd0);
    endtask

    task automatic send_word(input int i, input logic [31:0] w, input bit rnd_start, output int acc);
        for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], rnd_start, acc);
        wq.push_back('{addr: TB_BASE + 32'(i), data: w, cyc: acc});
    endtask

    // One full load session: expected image is word i at TB_BASE+i
    task automatic run_load(input int n, input bit dir, input bit rnd_start);
        int          acc;
        logic [31:0] w;
        start_sess();
        send_byte(n[15:8], 1'b0, acc);
        send_byte(n[7:0], 1'b0, acc);
        if (n == 0) begin
            dq.push_back(acc);
            wait_idle();
        end else if (n > TB_DEPTH) begin
            check1("err_state", {29'd0, busy, err, in_ready}, 32'd2);
            repeat (3) @(posedge clk);
            #1;
            check1("err_sticky", {29'd0, busy, err, in_ready}, 32'd2);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (dir) w = (i == 0) ? 32'h1234_5678 : 32'h9ABC_DEF0;
                else     w = $urandom;
                send_word(i, w, rnd_start, acc);
            end
            dq.push_back(acc + 1);
            wait_idle();
        end
    endtask

    initial begin
        int acc;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_ctl", {27'd0, in_ready, mem_we, busy, done, err}, 32'd0);
        check1("reset_addr", mem_addr, 32'd0);
        check1("reset_data", mem_wdata, 32'd0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check1("idle_no_start", {29'd0, busy, err, in_ready}, 32'd0);

        // Two directed words, no stalls
        run_load(2, 1'b1, 1'b0);
        // Zero-length load
        run_load(0, 1'b0, 1'b0);
        // Length one beyond depth, then a load started from the error state
        run_load(1002, 1'b0, 1'b0);
        run_load(1, 1'b0, 1'b0);
        // in_valid toggling every other cycle
        stall_lo = 1; stall_hi = 1;
        run_load(2, 1'b1, 1'b0);
        // start pulses during data are ignored
        stall_lo = 2; stall_hi = 0;
        run_load(3, 1'b0, 1'b1);

        // Reset after two bytes of word 1
        stall_lo = 0; stall_hi = 0;
        start_sess();
        send_byte(8'h00, 1'b0, acc);
        send_byte(8'h03, 1'b0, acc);
        send_word(0, 32'hCAFE_F00D, 1'b0, acc);
        send_byte(8'h11, 1'b0, acc);
        send_byte(8'h22, 1'b0, acc);
        #2;
        rst = 1'b0;
        #1;
        check1("async_reset_ctl", {27'd0, in_ready, mem_we, busy, done, err}, 32'd0);
        check1("async_reset_addr", mem_addr, 32'd0);
        check1("async_reset_data", mem_wdata, 32'd0);
        check1("reset_pending", 32'(wq.size() + dq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check1("post_reset_idle", {29'd0, busy, err, in_ready}, 32'd0);
        run_load(2, 1'b1, 1'b0);

        // Random sessions
        for (int k = 0; k < 14; k++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? (TB_DEPTH + 1 + int'($urandom_range(0, 3000)))
                                            : int'($urandom_range(0, 6));
            stall_lo = int'($urandom_range(0, 2));
            stall_hi = 0;
            run_load(n, 1'b0, 1'b1);
        end

        // Largest legal load
        stall_lo = 0; stall_hi = 0;
        run_load(TB_DEPTH, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
